// File: rtl/lsu_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : lsu_pkg                                                    |
// | Description : Shared definitions for the load/store unit: RV32I funct3   |
// |               encodings, FSM state encoding and the access-legality      |
// |               check applied when a request is accepted.                  |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_RD       = 3'd1,
    ST_WR       = 3'd2,
    ST_MERGE_WR = 3'd3,
    ST_DONE     = 3'd4
  } lsu_state_e;

  // Returns 1 when the access must be refused: illegal funct3 for the
  // direction, misaligned halfword/word, or word index beyond the memory.
  function automatic logic lsu_check_err(input logic        we,
                                         input logic [2:0]  funct3,
                                         input logic [31:0] addr,
                                         input logic [31:0] mem_words);
    logic illegal;
    logic misaligned;
    logic out_of_range;
    case (funct3)
      F3_B, F3_H, F3_W: illegal = 1'b0;
      F3_BU, F3_HU:     illegal = we;  // no unsigned store forms
      default:          illegal = 1'b1;
    endcase
    misaligned = 1'b0;
    if ((funct3 == F3_H || funct3 == F3_HU) && addr[0]) misaligned = 1'b1;
    if (funct3 == F3_W && addr[1:0] != 2'b00)           misaligned = 1'b1;
    out_of_range = ({2'b00, addr[31:2]} >= mem_words);
    return illegal | misaligned | out_of_range;
  endfunction

endpackage : lsu_pkg
`default_nettype wire

// File: rtl/lsu_align.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : lsu_align                                                  |
// | Description : Combinational byte/halfword lane logic. Extracts and       |
// |               sign/zero-extends a load value from a memory word, and     |
// |               builds the merged word for sub-word stores.                |
// | Ports       : word        - 32-bit memory word                           |
// |               byte_off    - address bits [1:0]                           |
// |               funct3      - RV32I load/store funct3                      |
// |               store_data  - store data (low byte/half for SB/SH)         |
// |               load_data   - extended load result                         |
// |               merged_word - word with target lane(s) replaced            |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module lsu_align
  import lsu_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  byte_off,
  input  logic [2:0]  funct3,
  input  logic [31:0] store_data,
  output logic [31:0] load_data,
  output logic [31:0] merged_word
);

  logic [7:0]  sel_byte;
  logic [15:0] sel_half;

  always_comb begin
    sel_byte = word[{byte_off, 3'b000} +: 8];
    sel_half = byte_off[1] ? word[31:16] : word[15:0];

    case (funct3)
      F3_B:    load_data = {{24{sel_byte[7]}}, sel_byte};
      F3_BU:   load_data = {24'h000000, sel_byte};
      F3_H:    load_data = {{16{sel_half[15]}}, sel_half};
      F3_HU:   load_data = {16'h0000, sel_half};
      default: load_data = word;
    endcase

    // Untouched lanes keep the value read from memory.
    merged_word = word;
    case (funct3)
      F3_B: merged_word[{byte_off, 3'b000} +: 8] = store_data[7:0];
      F3_H: begin
        if (byte_off[1]) merged_word[31:16] = store_data[15:0];
        else             merged_word[15:0]  = store_data[15:0];
      end
      default: merged_word = store_data;
    endcase
  end

endmodule : lsu_align
`default_nettype wire

// File: rtl/load_store_unit.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : load_store_unit                                            |
// | Description : MEM-stage initiator for a word-organised data memory.      |
// |               Handles LB/LH/LW/LBU/LHU/SB/SH/SW, using read-modify-write |
// |               for sub-word stores, and reports illegal accesses.         |
// | Ports       : clk, rst             - clock, sync active-high reset       |
// |               req_*                - request channel (valid/ready)       |
// |               resp_*               - one-cycle response pulse            |
// |               mem_*                - data memory interface               |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int unsigned MEM_WORDS = 256
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic        resp_err,
  output logic [31:0] resp_rdata,
  output logic        mem_read,
  output logic        mem_write,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);

  localparam logic [31:0] MEM_WORDS_W = 32'(MEM_WORDS);

  lsu_state_e  state_q, state_d;
  logic        we_q, we_d;
  logic [2:0]  funct3_q, funct3_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] merge_q, merge_d;
  logic        resp_err_q, resp_err_d;
  logic [31:0] resp_rdata_q, resp_rdata_d;

  logic [31:0] align_word;
  logic [31:0] load_data;
  logic [31:0] merged_word;

  // The aligner sees live memory data in RD (load extraction) and the
  // captured word in MERGE_WR (store merge).
  assign align_word = (state_q == ST_RD) ? mem_rdata : merge_q;

  lsu_align u_align (
    .word        (align_word),
    .byte_off    (addr_q[1:0]),
    .funct3      (funct3_q),
    .store_data  (wdata_q),
    .load_data   (load_data),
    .merged_word (merged_word)
  );

  always_comb begin
    state_d      = state_q;
    we_d         = we_q;
    funct3_d     = funct3_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    merge_d      = merge_q;
    resp_err_d   = resp_err_q;
    resp_rdata_d = resp_rdata_q;

    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          we_d         = req_we;
          funct3_d     = req_funct3;
          addr_d       = req_addr;
          wdata_d      = req_wdata;
          resp_rdata_d = 32'h0;
          resp_err_d   = lsu_check_err(req_we, req_funct3, req_addr, MEM_WORDS_W);
          if (resp_err_d)                          state_d = ST_DONE;
          else if (req_we && req_funct3 == F3_W)   state_d = ST_WR;
          else                                     state_d = ST_RD;
        end
      end
      ST_RD: begin
        if (we_q) begin
          merge_d = mem_rdata;
          state_d = ST_MERGE_WR;
        end else begin
          resp_rdata_d = load_data;
          state_d      = ST_DONE;
        end
      end
      ST_WR:       state_d = ST_DONE;
      ST_MERGE_WR: state_d = ST_DONE;
      ST_DONE: begin
        resp_err_d   = 1'b0;
        resp_rdata_d = 32'h0;
        state_d      = ST_IDLE;
      end
      default:     state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      we_q         <= 1'b0;
      funct3_q     <= 3'b000;
      addr_q       <= 32'h0;
      wdata_q      <= 32'h0;
      merge_q      <= 32'h0;
      resp_err_q   <= 1'b0;
      resp_rdata_q <= 32'h0;
    end else begin
      state_q      <= state_d;
      we_q         <= we_d;
      funct3_q     <= funct3_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      merge_q      <= merge_d;
      resp_err_q   <= resp_err_d;
      resp_rdata_q <= resp_rdata_d;
    end
  end

  // Memory strobes are pure state decodes, so they drop the cycle the FSM
  // leaves an access state and can never overlap.
  always_comb begin
    req_ready  = (state_q == ST_IDLE);
    resp_valid = (state_q == ST_DONE);
    resp_err   = resp_err_q;
    resp_rdata = resp_rdata_q;
    mem_read   = (state_q == ST_RD);
    mem_write  = (state_q == ST_WR) || (state_q == ST_MERGE_WR);
    mem_addr   = 32'h0;
    mem_wdata  = 32'h0;
    if (mem_read || mem_write) mem_addr = {addr_q[31:2], 2'b00};
    if (state_q == ST_WR)       mem_wdata = wdata_q;
    if (state_q == ST_MERGE_WR) mem_wdata = merged_word;
  end

endmodule : load_store_unit
`default_nettype wire

// File: tb/tb_load_store_unit.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_load_store_unit                                         |
// | Description : Self-checking bench for load_store_unit with a behavioural |
// |               word memory and a response scoreboard.                     |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module tb_load_store_unit;

  localparam int unsigned MEM_WORDS = 256;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic        resp_err;
  logic [31:0] resp_rdata;
  logic        mem_read;
  logic        mem_write;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  load_store_unit #(.MEM_WORDS(MEM_WORDS)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_funct3 (req_funct3),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_err   (resp_err),
    .resp_rdata (resp_rdata),
    .mem_read   (mem_read),
    .mem_write  (mem_write),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata)
  );

  always #5 clk = ~clk;

  // Behavioural data memory
  logic [31:0] mem [MEM_WORDS];
  int          tot_wr = 0;
  always @(posedge clk) begin
    if (mem_write) begin
      mem[mem_addr[9:2]] <= mem_wdata;
      tot_wr <= tot_wr + 1;
    end
  end
  assign mem_rdata = mem_read ? mem[mem_addr[9:2]] : 32'h0;

  typedef struct {
    logic        we;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        err;
    logic [31:0] rdata;
    int          lat;
    int          nrd;
    int          nwr;
    logic [31:0] wd;
  } vec_t;

  typedef struct {
    vec_t v;
    int   req_cyc;
  } exp_t;

  exp_t        sb[$];
  vec_t        vt[$];
  vec_t        pend;
  int          vectors = 0;
  int          miscompares = 0;
  int          n_acc = 0;
  int          cyc = 0;
  int          rd_cnt = 0;
  int          wr_cnt = 0;
  logic [31:0] last_wd = 32'h0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic vec_t mk(input logic we, input logic [2:0] f3,
                              input logic [31:0] a, input logic [31:0] wdat,
                              input logic err, input logic [31:0] rd,
                              input int lat, input int nrd, input int nwr,
                              input logic [31:0] mwd);
    vec_t v;
    v.we = we; v.f3 = f3; v.addr = a; v.wdata = wdat; v.err = err;
    v.rdata = rd; v.lat = lat; v.nrd = nrd; v.nwr = nwr; v.wd = mwd;
    return v;
  endfunction

  // Monitor / scoreboard, sampled on the falling edge
  always @(negedge clk) begin
    exp_t e;
    int   lat;
    if (rst) begin
      sb.delete();
    end else begin
      if (mem_read && mem_write) begin
        miscompares++;
        $display("FAIL rw_exclusive: mem_read=1 mem_write=1 at cycle %0d, required not both", cyc);
      end
      if (mem_addr[1:0] != 2'b00) begin
        miscompares++;
        $display("FAIL addr_align: mem_addr=%h, required bits[1:0]=00", mem_addr);
      end
      if (req_ready != (sb.size() == 0)) begin
        miscompares++;
        $display("FAIL ready_busy: req_ready=%0b with %0d outstanding at cycle %0d", req_ready, sb.size(), cyc);
      end
      if (mem_read) rd_cnt++;
      if (mem_write) begin
        wr_cnt++;
        last_wd = mem_wdata;
      end
      if (resp_valid) begin
        if (sb.size() == 0) begin
          miscompares++;
          $display("FAIL unexpected_resp: resp_valid=1 at cycle %0d, required 0", cyc);
        end else begin
          e = sb.pop_front();
          lat = cyc - e.req_cyc;
          vectors++;
          if (resp_err !== e.v.err || resp_rdata !== e.v.rdata || lat != e.v.lat ||
              rd_cnt != e.v.nrd || wr_cnt != e.v.nwr ||
              (e.v.nwr > 0 && last_wd !== e.v.wd)) begin
            miscompares++;
            $display("FAIL resp addr=%h: got err=%0b rdata=%h lat=%0d rd=%0d wr=%0d wd=%h, required err=%0b rdata=%h lat=%0d rd=%0d wr=%0d wd=%h",
                     e.v.addr, resp_err, resp_rdata, lat, rd_cnt, wr_cnt, last_wd,
                     e.v.err, e.v.rdata, e.v.lat, e.v.nrd, e.v.nwr, e.v.wd);
          end
        end
      end
      if (req_valid && req_ready) begin
        e.v = pend;
        e.req_cyc = cyc;
        sb.push_back(e);
        rd_cnt  = 0;
        wr_cnt  = 0;
        last_wd = 32'h0;
        n_acc++;
      end
    end
  end

  // Drive a request; called just after a rising edge.
  task automatic issue(input vec_t v);
    pend       = v;
    req_valid  = 1'b1;
    req_we     = v.we;
    req_funct3 = v.f3;
    req_addr   = v.addr;
    req_wdata  = v.wdata;
  endtask

  task automatic wait_accept();
    int start;
    int k;
    start = n_acc;
    k = 0;
    while (n_acc == start && k < 20) begin
      @(posedge clk); #1;
      k++;
    end
    if (n_acc == start) begin
      miscompares++;
      $display("FAIL accept_timeout: accepts=%0d, required %0d", n_acc, start + 1);
    end
  endtask

  task automatic wait_idle();
    int k;
    k = 0;
    while (sb.size() != 0 && k < 20) begin
      @(posedge clk); #1;
      k++;
    end
    if (sb.size() != 0) begin
      miscompares++;
      $display("FAIL resp_timeout: outstanding=%0d, required 0", sb.size());
      sb.delete();
    end
  endtask

  task automatic run_vec(input vec_t v);
    issue(v);
    wait_accept();
    req_valid = 1'b0;
    wait_idle();
  endtask

  initial begin
    logic [31:0] saved;
    int          wr_before;
    int          acc_before;

    for (int i = 0; i < int'(MEM_WORDS); i++) mem[i] = 32'h0;
    mem[4]   = 32'h8899AABB;
    mem[255] = 32'h5A5AA5A5;

    rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'b000;
    req_addr = 32'h0; req_wdata = 32'h0;
    pend = mk(1'b0, 3'b000, 32'h0, 32'h0, 1'b0, 32'h0, 0, 0, 0, 32'h0);

    repeat (3) @(posedge clk);
    #1;
    vectors++;
    if (req_ready !== 1'b1 || resp_valid !== 1'b0 || resp_err !== 1'b0 ||
        resp_rdata !== 32'h0 || mem_read !== 1'b0 || mem_write !== 1'b0 ||
        mem_addr !== 32'h0 || mem_wdata !== 32'h0) begin
      miscompares++;
      $display("FAIL reset_state: ready=%0b rv=%0b err=%0b rdata=%h rd=%0b wr=%0b addr=%h wd=%h, required 1 0 0 0 0 0 0 0",
               req_ready, resp_valid, resp_err, resp_rdata, mem_read, mem_write, mem_addr, mem_wdata);
    end
    rst = 1'b0;
    @(posedge clk); #1;

    //          we    f3      addr          wdata         err   rdata         lat nrd nwr mem_wdata
    vt.push_back(mk(1'b0, 3'b010, 32'h10,  32'h0,        1'b0, 32'h8899AABB, 2, 1, 0, 32'h0));
    vt.push_back(mk(1'b0, 3'b000, 32'h13,  32'h0,        1'b0, 32'hFFFFFF88, 2, 1, 0, 32'h0));
    vt.push_back(mk(1'b0, 3'b100, 32'h13,  32'h0,        1'b0, 32'h00000088, 2, 1, 0, 32'h0));
    vt.push_back(mk(1'b0, 3'b001, 32'h12,  32'h0,        1'b0, 32'hFFFF8899, 2, 1, 0, 32'h0));
    vt.push_back(mk(1'b0, 3'b101, 32'h10,  32'h0,        1'b0, 32'h0000AABB, 2, 1, 0, 32'h0));
    vt.push_back(mk(1'b0, 3'b000, 32'h10,  32'h0,        1'b0, 32'hFFFFFFBB, 2, 1, 0, 32'h0));
    vt.push_back(mk(1'b0, 3'b100, 32'h11,  32'h0,        1'b0, 32'h000000AA, 2, 1, 0, 32'h0));
    vt.push_back(mk(1'b1, 3'b000, 32'h11,  32'h12345677, 1'b0, 32'h0,        3, 1, 1, 32'h889977BB));
    vt.push_back(mk(1'b0, 3'b010, 32'h10,  32'h0,        1'b0, 32'h889977BB, 2, 1, 0, 32'h0));
    vt.push_back(mk(1'b1, 3'b010, 32'h10,  32'h8899AABB, 1'b0, 32'h0,        2, 0, 1, 32'h8899AABB));
    vt.push_back(mk(1'b1, 3'b001, 32'h12,  32'h0000CAFE, 1'b0, 32'h0,        3, 1, 1, 32'hCAFEAABB));
    vt.push_back(mk(1'b0, 3'b010, 32'h10,  32'h0,        1'b0, 32'hCAFEAABB, 2, 1, 0, 32'h0));
    vt.push_back(mk(1'b1, 3'b001, 32'h13,  32'h0,        1'b1, 32'h0,        1, 0, 0, 32'h0));
    vt.push_back(mk(1'b0, 3'b010, 32'h400, 32'h0,        1'b1, 32'h0,        1, 0, 0, 32'h0));
    vt.push_back(mk(1'b0, 3'b011, 32'h10,  32'h0,        1'b1, 32'h0,        1, 0, 0, 32'h0));
    vt.push_back(mk(1'b1, 3'b100, 32'h10,  32'h0,        1'b1, 32'h0,        1, 0, 0, 32'h0));
    vt.push_back(mk(1'b0, 3'b001, 32'h11,  32'h0,        1'b1, 32'h0,        1, 0, 0, 32'h0));
    vt.push_back(mk(1'b1, 3'b010, 32'h3FE, 32'h0,        1'b1, 32'h0,        1, 0, 0, 32'h0));
    vt.push_back(mk(1'b0, 3'b010, 32'h3FC, 32'h0,        1'b0, 32'h5A5AA5A5, 2, 1, 0, 32'h0));
    vt.push_back(mk(1'b0, 3'b101, 32'h3FE, 32'h0,        1'b0, 32'h00005A5A, 2, 1, 0, 32'h0));
    vt.push_back(mk(1'b0, 3'b001, 32'h3FC, 32'h0,        1'b0, 32'hFFFFA5A5, 2, 1, 0, 32'h0));
    vt.push_back(mk(1'b1, 3'b010, 32'h400, 32'h0,        1'b1, 32'h0,        1, 0, 0, 32'h0));

    for (int i = 0; i < vt.size(); i++) run_vec(vt[i]);

    // Reset while an SB sits in RD: the merge write must never happen.
    saved     = mem[4];
    wr_before = tot_wr;
    issue(mk(1'b1, 3'b000, 32'h10, 32'h00000055, 1'b0, 32'h0, 3, 1, 1, 32'h0));
    wait_accept();
    req_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    vectors++;
    if (req_ready !== 1'b1 || mem_read !== 1'b0 || mem_write !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_midop_ready: ready=%0b rd=%0b wr=%0b, required 1 0 0", req_ready, mem_read, mem_write);
    end
    repeat (4) @(posedge clk);
    #1;
    vectors++;
    if (mem[4] !== saved || tot_wr != wr_before) begin
      miscompares++;
      $display("FAIL reset_midop_mem: mem[4]=%h writes=%0d, required %h writes=%0d", mem[4], tot_wr, saved, wr_before);
    end

    // Back-to-back with req_valid held high throughout.
    acc_before = n_acc;
    issue(mk(1'b0, 3'b010, 32'h3FC, 32'h0,        1'b0, 32'h5A5AA5A5, 2, 1, 0, 32'h0));
    wait_accept();
    issue(mk(1'b1, 3'b010, 32'h20,  32'hDEADBEEF, 1'b0, 32'h0,        2, 0, 1, 32'hDEADBEEF));
    wait_accept();
    issue(mk(1'b1, 3'b000, 32'h21,  32'h00000011, 1'b0, 32'h0,        3, 1, 1, 32'hDEAD11EF));
    wait_accept();
    req_valid = 1'b0;
    wait_idle();
    repeat (3) @(posedge clk);
    #1;
    vectors++;
    if (n_acc - acc_before != 3) begin
      miscompares++;
      $display("FAIL b2b_accepts: accepted=%0d, required 3", n_acc - acc_before);
    end
    run_vec(mk(1'b0, 3'b010, 32'h20, 32'h0, 1'b0, 32'hDEAD11EF, 2, 1, 0, 32'h0));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule : tb_load_store_unit
`default_nettype wire
